adder_result_buffer: RTL and testbench

Downstream stage of the 4-bit adder (`F_adder`). Captures each `{c_out, s}` result the adder produces into a small first-word-fall-through FIFO with a valid/ready handshake, so a slower consumer can drain results at its own rate. It also keeps a saturating count of overflowed results (`c_out = 1`).

---
 rtl/adder_result_buffer.sv | 87 ++++++++
 tb/tb_adder_result_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_buffer.sv
// adder_result_buffer: FWFT FIFO capturing {c_out, s} results from the 4-bit
// adder, with a valid/ready handshake on both sides and a saturating count
// of accepted results that carried out.
module adder_result_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [3:0]               in_s,
    input  logic                     in_c_out,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [4:0]               out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         ovf_count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned DATA_W = 5;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  ovf_cnt_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Status derived from registered pointers only; no ready passthrough.
    always_comb begin
        full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        empty = (wr_ptr == rd_ptr);
        push  = in_valid && !full;
        pop   = out_ready && !empty;
    end

    // Port views of the status and the head entry (zero when empty).
    always_comb begin
        in_ready  = !full;
        out_valid = !empty;
        level     = wr_ptr - rd_ptr;
        ovf_count = ovf_cnt_q;
        out_data  = '0;
        if (!empty) begin
            out_data = mem[rd_ptr[AW-1:0]];
        end
    end

    // Pointer advance on accepted push / pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_c_out, in_s};
        end
    end

    // Saturating count of accepted results with carry-out set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else if (push && in_c_out && (ovf_cnt_q != {CNT_W{1'b1}})) begin
            ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_adder_result_buffer.sv
// Directed testbench for adder_result_buffer: default instance plus a
// CNT_W=2 instance for counter saturation.
module tb_adder_result_buffer;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid;
    logic [3:0] in_s;
    logic       in_c_out;
    logic       in_ready;
    logic       out_valid;
    logic [4:0] out_data;
    logic       out_ready;
    logic [2:0] level;
    logic [7:0] ovf_count;

    logic       s_in_valid;
    logic [3:0] s_in_s;
    logic       s_in_c_out;
    logic       s_in_ready;
    logic       s_out_valid;
    logic [4:0] s_out_data;
    logic       s_out_ready;
    logic [2:0] s_level;
    logic [1:0] s_ovf_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_result_buffer #(.DEPTH(4), .CNT_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_s      (in_s),
        .in_c_out  (in_c_out),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .ovf_count (ovf_count)
    );

    adder_result_buffer #(.DEPTH(4), .CNT_W(2)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_s      (s_in_s),
        .in_c_out  (s_in_c_out),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ready (s_out_ready),
        .level     (s_level),
        .ovf_count (s_ovf_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] d);
        in_valid = v;
        in_c_out = d[4];
        in_s     = d[3:0];
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_s        = 4'd0;
        in_c_out    = 1'b0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_s      = 4'd0;
        s_in_c_out  = 1'b0;
        s_out_ready = 1'b0;

        // Reset values while rst is held
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(ovf_count), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_level", 32'(level), 32'd0);

        // Adder sequence 0+0, 1+1, 15+15 with consumer stalled
        drive(1'b1, 5'h00); step();
        drive(1'b1, 5'h02); step();
        drive(1'b1, 5'h1E); step();
        drive(1'b0, 5'h00);
        chk("seq_level", 32'(level), 32'd3);
        chk("seq_head", 32'(out_data), 32'h00);
        chk("seq_ovf", 32'(ovf_count), 32'd1);
        chk("seq_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        chk("drain0", 32'(out_data), 32'h00); step();
        chk("drain1", 32'(out_data), 32'h02); step();
        chk("drain2", 32'(out_data), 32'h1E); step();
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_data0", 32'(out_data), 32'd0);
        out_ready = 1'b0;

        // Fill to DEPTH, offer a fifth while full, then pop once
        drive(1'b1, 5'h01); step();
        drive(1'b1, 5'h02); step();
        drive(1'b1, 5'h03); step();
        drive(1'b1, 5'h14); step();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_level", 32'(level), 32'd4);
        drive(1'b1, 5'h05); step();
        chk("full_drop_level", 32'(level), 32'd4);
        chk("full_drop_head", 32'(out_data), 32'h01);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("after_pop_level", 32'(level), 32'd3);
        chk("after_pop_ready", 32'(in_ready), 32'd1);
        chk("after_pop_head", 32'(out_data), 32'h02);
        step();
        drive(1'b0, 5'h00);
        chk("fifth_level", 32'(level), 32'd4);
        chk("fill_ovf", 32'(ovf_count), 32'd2);
        out_ready = 1'b1;
        chk("fd0", 32'(out_data), 32'h02); step();
        chk("fd1", 32'(out_data), 32'h03); step();
        chk("fd2", 32'(out_data), 32'h14); step();
        chk("fd3_fifth", 32'(out_data), 32'h05); step();
        chk("fd_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Async reset with three entries stored
        drive(1'b1, 5'h1F); step();
        drive(1'b1, 5'h00); step();
        drive(1'b1, 5'h11); step();
        drive(1'b0, 5'h00);
        chk("pre_rst_level", 32'(level), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_ovf", 32'(ovf_count), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_data", 32'(out_data), 32'd0);
        step();
        rst = 1'b0;
        drive(1'b1, 5'h0A); step();
        drive(1'b0, 5'h00);
        chk("post_rst_data", 32'(out_data), 32'h0A);
        chk("post_rst_level", 32'(level), 32'd1);
        out_ready = 1'b1;
        step();
        chk("post_rst_empty", 32'(out_valid), 32'd0);

        // Streaming 16 values through pointer wrap
        for (int i = 0; i < 16; i++) begin
            logic [3:0] sv;
            sv = 4'(i);
            drive(1'b1, {sv[3], sv});
            step();
            chk($sformatf("stream_level_%0d", i), 32'(level), 32'd1);
            chk($sformatf("stream_data_%0d", i), 32'(out_data), 32'({sv[3], sv}));
        end
        drive(1'b0, 5'h00);
        chk("stream_ovf", 32'(ovf_count), 32'd8);
        step();
        chk("stream_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Counter saturation on the CNT_W=2 instance
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        s_in_c_out  = 1'b1;
        s_in_s      = 4'h7;
        step(); chk("sat_1", 32'(s_ovf_count), 32'd1);
        step(); chk("sat_2", 32'(s_ovf_count), 32'd2);
        step(); chk("sat_3", 32'(s_ovf_count), 32'd3);
        step(); chk("sat_4", 32'(s_ovf_count), 32'd3);
        step(); chk("sat_5", 32'(s_ovf_count), 32'd3);
        s_in_valid = 1'b0;
        step();
        chk("sat_hold", 32'(s_ovf_count), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
